// File: rtl/core_pkg.sv
// Shared encodings for the RV32 pipeline hazard logic: forwarding selects,
// hazard FSM states and pipeline stage indices.
package core_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FREEZE = 1'b1
  } hz_state_t;

  // A load in EX cannot forward yet; its data is only reachable one stage later.
  function automatic fwd_sel_t fwd_pick(input logic i_ex_hit, input logic i_ex_lw,
                                        input logic i_mem_hit);
    if (i_ex_hit && !i_ex_lw) return FWD_MEM;
    if (i_mem_hit) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Register dependency comparator: a writer's rd matches a reader's rs.
// x0 never matches.
module hz_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_wr,
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_use,
  output logic              o_match
);

  assign o_match = i_wr && i_use && (i_rd != '0) && (i_rd == i_rs);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core (holds, bubble, flush,
// forwarding). HAZARD_FWD_EN builds forwarding/bypass; otherwise RAW hazards stall.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = STG_MEM,
  parameter int CNT_W    = 32
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [REG_AW-1:0]   i_id_rs1,
  input  logic [REG_AW-1:0]   i_id_rs2,
  input  logic                i_id_use_rs1,
  input  logic                i_id_use_rs2,
  input  logic [REG_AW-1:0]   i_ex_rd,
  input  logic [REG_AW-1:0]   i_mem_rd,
  input  logic [REG_AW-1:0]   i_wb_rd,
  input  logic                i_ex_wr,
  input  logic                i_mem_wr,
  input  logic                i_wb_wr,
  input  logic                i_ex_lw,
  input  logic                i_redirect,
  input  logic                i_dmem_busy,
  output logic                o_hold_pc,
  output logic                o_hold_if_id,
  output logic                o_hold_id_ex,
  output logic                o_hold_ex_mem,
  output logic                o_hold_mem_wb,
  output logic                o_bubble_ex,
  output logic [BR_STAGE-1:0] o_flush,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b,
  output logic                o_byp_a,
  output logic                o_byp_b,
  output logic [CNT_W-1:0]    o_stall_cnt,
  output logic [CNT_W-1:0]    o_flush_cnt,
  output logic                o_frozen
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;

  hz_match #(.REG_AW(REG_AW)) u_ex_a  (.i_rd(i_ex_rd),  .i_wr(i_ex_wr),  .i_rs(i_id_rs1), .i_use(i_id_use_rs1), .o_match(w_ex_a));
  hz_match #(.REG_AW(REG_AW)) u_ex_b  (.i_rd(i_ex_rd),  .i_wr(i_ex_wr),  .i_rs(i_id_rs2), .i_use(i_id_use_rs2), .o_match(w_ex_b));
  hz_match #(.REG_AW(REG_AW)) u_mem_a (.i_rd(i_mem_rd), .i_wr(i_mem_wr), .i_rs(i_id_rs1), .i_use(i_id_use_rs1), .o_match(w_mem_a));
  hz_match #(.REG_AW(REG_AW)) u_mem_b (.i_rd(i_mem_rd), .i_wr(i_mem_wr), .i_rs(i_id_rs2), .i_use(i_id_use_rs2), .o_match(w_mem_b));
  hz_match #(.REG_AW(REG_AW)) u_wb_a  (.i_rd(i_wb_rd),  .i_wr(i_wb_wr),  .i_rs(i_id_rs1), .i_use(i_id_use_rs1), .o_match(w_wb_a));
  hz_match #(.REG_AW(REG_AW)) u_wb_b  (.i_rd(i_wb_rd),  .i_wr(i_wb_wr),  .i_rs(i_id_rs2), .i_use(i_id_use_rs2), .o_match(w_wb_b));

  hz_state_t               r_state;
  logic                    r_redirect_pend;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic [CNT_W-1:0]        r_flush_cnt;

  logic                    w_busy;
  logic                    w_flush_now;
  logic                    w_load_use;
  logic                    w_stall;
  logic [STG_WB:STG_IF]    w_hold;
  logic [BR_STAGE-1:0]     w_flush;

  // Memory wait outranks redirect, which outranks any stall. A redirect seen
  // while frozen is replayed as one flush in the first free cycle.
  always_comb begin
    w_busy      = i_dmem_busy;
    w_flush_now = !w_busy && (i_redirect || r_redirect_pend);
    w_load_use  = i_ex_lw && (w_ex_a || w_ex_b);
`ifdef HAZARD_FWD_EN
    w_stall     = !w_busy && !w_flush_now && w_load_use;
`else
    w_stall     = !w_busy && !w_flush_now &&
                  (w_load_use || w_ex_a || w_ex_b || w_mem_a || w_mem_b || w_wb_a || w_wb_b);
`endif
    w_hold          = {(STG_WB - STG_IF + 1){w_busy}};
    w_hold[STG_IF]  = w_busy || w_stall;
    w_hold[STG_ID]  = w_busy || w_stall;
    w_flush         = {BR_STAGE{w_flush_now}};
  end

  assign o_hold_pc     = w_hold[STG_IF];
  assign o_hold_if_id  = w_hold[STG_ID];
  assign o_hold_id_ex  = w_hold[STG_EX];
  assign o_hold_ex_mem = w_hold[STG_MEM];
  assign o_hold_mem_wb = w_hold[STG_WB];
  assign o_bubble_ex   = w_stall;
  assign o_flush       = w_flush;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;
  assign o_frozen      = (r_state == ST_FREEZE);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= ST_RUN;
      r_redirect_pend <= 1'b0;
      r_stall_cnt     <= '0;
      r_flush_cnt     <= '0;
    end else begin
      case (r_state)
        ST_RUN:    if (w_busy)  r_state <= ST_FREEZE;
        ST_FREEZE: if (!w_busy) r_state <= ST_RUN;
        default:                r_state <= ST_RUN;
      endcase
      r_redirect_pend <= w_busy && (r_redirect_pend || i_redirect);
      if (w_stall && (r_stall_cnt != '1))     r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_now && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

`ifdef HAZARD_FWD_EN
  fwd_sel_t r_fwd_a;
  fwd_sel_t r_fwd_b;

  // Selects follow the instruction into EX; a bubble or flushed slot carries none.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (!w_hold[STG_EX]) begin
      if (w_stall || w_flush[STG_ID]) begin
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_fwd_a <= fwd_pick(w_ex_a, i_ex_lw, w_mem_a);
        r_fwd_b <= fwd_pick(w_ex_b, i_ex_lw, w_mem_b);
      end
    end
  end

  assign o_fwd_a = r_fwd_a;
  assign o_fwd_b = r_fwd_b;
  assign o_byp_a = w_wb_a;
  assign o_byp_b = w_wb_b;
`else
  assign o_fwd_a = FWD_RF;
  assign o_fwd_b = FWD_RF;
  assign o_byp_a = 1'b0;
  assign o_byp_b = 1'b0;
`endif

endmodule
